sel_mux_pipe: RTL and testbench

SEL_MUX_PIPE -- requirements
Module: sel_mux_pipe

---
 rtl/sel_mux_pipe.sv | 94 +++++++++
 tb/tb_sel_mux_pipe.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sel_mux_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : sel_mux_pipe
//  Purpose  : Select one of NUM_IN channels per beat and stage it through a
//             two-entry (output + skid) valid/ready register pipeline.
//  Revision : 1.0  initial release
// ============================================================================
module sel_mux_pipe #(
   parameter int WIDTH        = 32,
   parameter int NUM_IN       = 4,
   parameter int SEL_W        = 2,
   parameter int DROP_BAD_SEL = 1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [NUM_IN*WIDTH-1:0] data_i,
   input  logic [SEL_W-1:0]        select_i,
   input  logic                    valid_i,
   output logic                    ready_o,
   input  logic                    flush_i,
   output logic [WIDTH-1:0]        data_o,
   output logic                    valid_o,
   input  logic                    ready_i,
   output logic                    sel_err_o
);

   localparam logic [31:0] c_NUM_IN = 32'(NUM_IN);
   localparam logic        c_DROP   = (DROP_BAD_SEL != 0);

   logic [WIDTH-1:0] r_out_data;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_skid_data;
   logic             r_skid_valid;
   logic             r_sel_err;

   logic [WIDTH-1:0] w_sel_data;
   logic             w_in_range;
   logic             w_accept;
   logic             w_store;
   logic             w_out_free;

   // Out-of-range selects resolve to zero data, used when bad beats are kept.
   always_comb begin
      w_sel_data = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         if (32'(select_i) == 32'(k))
            w_sel_data = data_i[k*WIDTH +: WIDTH];
      end
   end

   assign w_in_range = (32'(select_i) < c_NUM_IN);
   assign w_accept   = valid_i & ~r_skid_valid;
   assign w_store    = w_accept & (w_in_range | ~c_DROP);
   assign w_out_free = ~r_out_valid | ready_i;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_out_data   <= '0;
         r_out_valid  <= 1'b0;
         r_skid_data  <= '0;
         r_skid_valid <= 1'b0;
         r_sel_err    <= 1'b0;
      end else begin
         // Error pulse reflects acceptance only, so a flush never hides it.
         r_sel_err <= w_accept & ~w_in_range;
         if (flush_i) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
         end else if (w_out_free) begin
            if (r_skid_valid) begin
               r_out_data   <= r_skid_data;
               r_out_valid  <= 1'b1;
               r_skid_valid <= w_store;
               if (w_store)
                  r_skid_data <= w_sel_data;
            end else begin
               r_out_valid <= w_store;
               if (w_store)
                  r_out_data <= w_sel_data;
            end
         end else if (w_store) begin
            r_skid_data  <= w_sel_data;
            r_skid_valid <= 1'b1;
         end
      end
   end

   assign ready_o   = ~r_skid_valid;
   assign data_o    = r_out_data;
   assign valid_o   = r_out_valid;
   assign sel_err_o = r_sel_err;

endmodule
`default_nettype wire

// File: tb/tb_sel_mux_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sel_mux_pipe
//  Purpose  : Directed self-checking bench for sel_mux_pipe (default build
//             plus two 3-channel builds for drop / keep of bad selects).
//  Revision : 1.0  initial release
// ============================================================================
module tb_sel_mux_pipe;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic [127:0]  data_i;
   logic [1:0]    select_i;
   logic          valid_i;
   logic          flush_i;
   logic          ready_i;

   logic          ready_o,   drp_ready_o,   kp_ready_o;
   logic [31:0]   data_o,    drp_data_o,    kp_data_o;
   logic          valid_o,   drp_valid_o,   kp_valid_o;
   logic          sel_err_o, drp_sel_err_o, kp_sel_err_o;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk_i = ~clk_i;

   sel_mux_pipe u_dut (
      .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .select_i(select_i),
      .valid_i(valid_i), .ready_o(ready_o), .flush_i(flush_i),
      .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
      .sel_err_o(sel_err_o)
   );

   sel_mux_pipe #(.WIDTH(32), .NUM_IN(3), .SEL_W(2), .DROP_BAD_SEL(1)) u_drop (
      .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i[95:0]), .select_i(select_i),
      .valid_i(valid_i), .ready_o(drp_ready_o), .flush_i(flush_i),
      .data_o(drp_data_o), .valid_o(drp_valid_o), .ready_i(ready_i),
      .sel_err_o(drp_sel_err_o)
   );

   sel_mux_pipe #(.WIDTH(32), .NUM_IN(3), .SEL_W(2), .DROP_BAD_SEL(0)) u_keep (
      .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i[95:0]), .select_i(select_i),
      .valid_i(valid_i), .ready_o(kp_ready_o), .flush_i(flush_i),
      .data_o(kp_data_o), .valid_o(kp_valid_o), .ready_i(ready_i),
      .sel_err_o(kp_sel_err_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_ch(input int k, input logic [31:0] v);
      data_i[k*32 +: 32] = v;
   endtask

   task automatic offer(input logic [1:0] sel, input logic [31:0] v);
      set_ch(int'(sel), v);
      select_i = sel;
      valid_i  = 1'b1;
   endtask

   initial begin
      rst_i    = 1'b0;
      data_i   = '0;
      select_i = '0;
      valid_i  = 1'b0;
      flush_i  = 1'b0;
      ready_i  = 1'b1;
      step();
      step();
      chk("rst_valid", {31'd0, valid_o}, 32'd0);
      chk("rst_ready", {31'd0, ready_o}, 32'd1);
      chk("rst_data",  data_o, 32'd0);
      chk("rst_err",   {31'd0, sel_err_o}, 32'd0);
      rst_i = 1'b1;

      // Single beat, latency 1
      set_ch(0, 32'h0BAD0000); set_ch(1, 32'h0BAD0001); set_ch(3, 32'h0BAD0003);
      offer(2'd2, 32'hDEADBEEF);
      step();
      valid_i = 1'b0;
      chk("single_data",  data_o, 32'hDEADBEEF);
      chk("single_valid", {31'd0, valid_o}, 32'd1);
      step();
      chk("single_gone",  {31'd0, valid_o}, 32'd0);

      // Back-pressure: A in OUT, B in SKID, C held off
      ready_i = 1'b0;
      offer(2'd0, 32'hAAAA0000);
      step();
      chk("bp_a_ready", {31'd0, ready_o}, 32'd1);
      offer(2'd1, 32'hBBBB1111);
      step();
      chk("bp_full_ready", {31'd0, ready_o}, 32'd0);
      chk("bp_full_data",  data_o, 32'hAAAA0000);
      offer(2'd3, 32'hCCCC3333);
      step();
      chk("bp_c_ready", {31'd0, ready_o}, 32'd0);
      chk("bp_c_data",  data_o, 32'hAAAA0000);
      set_ch(0, 32'hFFFF0000);
      set_ch(1, 32'hFFFF1111);
      ready_i = 1'b1;
      step();
      chk("bp_b_data",  data_o, 32'hBBBB1111);
      chk("bp_b_valid", {31'd0, valid_o}, 32'd1);
      chk("bp_b_ready", {31'd0, ready_o}, 32'd1);
      step();
      valid_i = 1'b0;
      chk("bp_c_out", data_o, 32'hCCCC3333);
      chk("bp_c_vld", {31'd0, valid_o}, 32'd1);
      step();
      chk("bp_drained", {31'd0, valid_o}, 32'd0);

      // Out-of-range select on the 3-channel builds
      set_ch(0, 32'h01010101); set_ch(1, 32'h02020202); set_ch(2, 32'h03030303);
      offer(2'd3, 32'h44444444);
      step();
      valid_i = 1'b0;
      chk("drop_err",   {31'd0, drp_sel_err_o}, 32'd1);
      chk("drop_valid", {31'd0, drp_valid_o}, 32'd0);
      chk("keep_err",   {31'd0, kp_sel_err_o}, 32'd1);
      chk("keep_valid", {31'd0, kp_valid_o}, 32'd1);
      chk("keep_data",  kp_data_o, 32'd0);
      chk("main_err",   {31'd0, sel_err_o}, 32'd0);
      chk("main_data3", data_o, 32'h44444444);
      step();
      chk("drop_err_end", {31'd0, drp_sel_err_o}, 32'd0);
      chk("drop_still",   {31'd0, drp_valid_o}, 32'd0);
      chk("keep_gone",    {31'd0, kp_valid_o}, 32'd0);

      // Flush of a full block with a beat offered
      ready_i = 1'b0;
      offer(2'd1, 32'h1111AAAA);
      step();
      offer(2'd2, 32'h2222BBBB);
      step();
      chk("fl_full", {31'd0, ready_o}, 32'd0);
      flush_i = 1'b1;
      offer(2'd0, 32'h5A5A5A5A);
      step();
      flush_i = 1'b0;
      valid_i = 1'b0;
      chk("fl_valid", {31'd0, valid_o}, 32'd0);
      chk("fl_ready", {31'd0, ready_o}, 32'd1);
      ready_i = 1'b1;
      step();
      chk("fl_none", {31'd0, valid_o}, 32'd0);

      // Reset while full
      ready_i = 1'b0;
      offer(2'd1, 32'h77771111);
      step();
      offer(2'd3, 32'h77773333);
      step();
      chk("rf_full", {31'd0, ready_o}, 32'd0);
      rst_i = 1'b0;
      offer(2'd0, 32'h99990000);
      step();
      chk("rf_valid", {31'd0, valid_o}, 32'd0);
      chk("rf_ready", {31'd0, ready_o}, 32'd1);
      chk("rf_data",  data_o, 32'd0);
      rst_i   = 1'b1;
      ready_i = 1'b1;
      offer(2'd2, 32'h12345678);
      step();
      valid_i = 1'b0;
      chk("rf_lat1_data",  data_o, 32'h12345678);
      chk("rf_lat1_valid", {31'd0, valid_o}, 32'd1);

      // Full throughput, selects cycling 0..3
      for (int k = 0; k < 4; k++) set_ch(k, 32'hC0DE0000 + 32'(k));
      valid_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         select_i = 2'(i % 4);
         step();
         chk($sformatf("tp_data%0d", i), data_o, 32'hC0DE0000 + 32'(i % 4));
         chk($sformatf("tp_vld%0d", i), {31'd0, valid_o}, 32'd1);
         chk($sformatf("tp_rdy%0d", i), {31'd0, ready_o}, 32'd1);
      end
      valid_i = 1'b0;
      step();
      chk("tp_end", {31'd0, valid_o}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
